// File: rtl/my_stream_mux_rr.sv
// ---------------------------------------------------------------------------
// my_stream_mux_rr
// N-way stream multiplexer with valid/ready handshakes. Arbitrates among
// CHANNELS producers (round-robin or fixed priority) and forwards one beat
// per cycle into a single registered output stage. With PKT_LOCK=1 the grant
// stays on one channel until a beat carrying last has been accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    CHANNELS*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel beat valid
//   in_last    per-channel end-of-packet flag
//   in_ready   per-channel accept, one-hot or zero
//   out_data   registered selected beat
//   out_last   registered last flag of the selected beat
//   out_sel    registered source channel index
//   out_valid  output beat valid
//   out_ready  consumer accept
// ---------------------------------------------------------------------------
module my_stream_mux_rr #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 8,
   parameter int RR_MODE  = 1,
   parameter int PKT_LOCK = 0,
   localparam int SEL_W   = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS-1:0]       in_last,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_last,
   output logic [SEL_W-1:0]          out_sel,
   output logic                      out_valid,
   input  logic                      out_ready
);

   localparam int unsigned NCH = CHANNELS;

   typedef enum logic {ARB, LOCK} state_t;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] lock_q, lock_d;

   logic             load;
   logic             gnt_vld;
   logic [SEL_W-1:0] gnt;
   logic             xfer;
   logic [WIDTH-1:0] ch_data [CHANNELS];

   logic [WIDTH-1:0] data_p1;
   logic             last_p1;
   logic [SEL_W-1:0] sel_p1;
   logic             vld_p1;

   // Channel index (base + k) mod CHANNELS; never leaves 0..CHANNELS-1, so
   // non-power-of-two channel counts stay in range.
   function automatic logic [SEL_W-1:0] idx_add(input logic [SEL_W-1:0] base,
                                                input int unsigned      k);
      int unsigned s;
      s = int'(base) + k;
      if (s >= NCH) s = s - NCH;
      return s[SEL_W-1:0];
   endfunction

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) ch_data[i] = in_data[i*WIDTH +: WIDTH];
   end

   assign load = !vld_p1 || out_ready;

   // Arbitration. The scan runs backwards so the last hit is the first
   // valid channel in scan order starting from the base.
   always_comb begin
      logic [SEL_W-1:0] base;
      logic [SEL_W-1:0] c;
      gnt_vld = 1'b0;
      gnt     = '0;
      base    = (RR_MODE != 0) ? ptr_q : '0;
      c       = '0;
      if (state_q == LOCK) begin
         gnt     = lock_q;
         gnt_vld = in_valid[lock_q];
      end else begin
         for (int k = CHANNELS - 1; k >= 0; k--) begin
            c = idx_add(base, unsigned'(k));
            if (in_valid[c]) begin
               gnt_vld = 1'b1;
               gnt     = c;
            end
         end
      end
   end

   assign xfer = load && gnt_vld && !rst;

   always_comb begin
      in_ready = '0;
      if (xfer) in_ready[gnt] = 1'b1;
   end

   // Next pointer / lock state
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      lock_d  = lock_q;
      if (xfer) begin
         if (RR_MODE != 0) ptr_d = idx_add(gnt, 1);
         if (PKT_LOCK != 0) begin
            if (state_q == ARB && !in_last[gnt]) begin
               state_d = LOCK;
               lock_d  = gnt;
            end else if (state_q == LOCK && in_last[gnt]) begin
               state_d = ARB;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB;
         ptr_q   <= '0;
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
      end
   end

   // ---- stage p1: registered output beat ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         last_p1 <= 1'b0;
         sel_p1  <= '0;
      end else if (load) begin
         vld_p1 <= gnt_vld;
         if (gnt_vld) begin
            data_p1 <= ch_data[gnt];
            last_p1 <= in_last[gnt];
            sel_p1  <= gnt;
         end
      end
   end

   assign out_valid = vld_p1;
   assign out_data  = data_p1;
   assign out_last  = last_p1;
   assign out_sel   = sel_p1;

endmodule
